// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - memory-mapped 8N1 UART transmitter with byte FIFO and sticky overflow
module uart_tx #(
  parameter int DIVISOR = 434,
  parameter int DEPTH   = 4
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       ovf_clr,
  output logic       tx,
  output logic       full,
  output logic       busy,
  output logic       ovf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [15:0]   BAUD_LAST = 16'(DIVISOR - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [15:0]   baud, baud_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic          push, pop, drop, bit_end;

  // A write is dropped whenever the FIFO was full before the edge, even if a pop frees a slot that cycle.
  assign full    = (count == DEPTH_C);
  assign push    = wr_en & ~full;
  assign drop    = wr_en & full;
  assign bit_end = (baud == BAUD_LAST);
  assign busy    = (state != IDLE) || (count != '0);

  // Next-state, serializer datapath and FIFO pop decision.
  always_comb begin
    state_n = state;
    baud_n  = baud;
    idx_n   = idx;
    shift_n = shift;
    tx_n    = tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
          baud_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_n  = '0;
          tx_n    = shift[0];
          idx_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_n = '0;
          if (idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            shift_n = {1'b0, shift[7:1]};
            tx_n    = shift[1];
            idx_n   = idx + 3'd1;
          end
        end else begin
          baud_n = baud + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_n = '0;
          // Chain straight into the next start bit so back-to-back frames have no idle gap.
          if (count != '0) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + 16'd1;
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  // FSM and serializer registers; reset returns the line high immediately, abandoning any frame.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      baud  <= '0;
      idx   <= '0;
      shift <= '0;
      tx    <= 1'b1;
    end else begin
      state <= state_n;
      baud  <= baud_n;
      idx   <= idx_n;
      shift <= shift_n;
      tx    <= tx_n;
    end
  end

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clkin) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear wins.
  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - randomized self-checking bench for uart_tx against a frame-timeline model
module tb_uart_tx;

  localparam int D  = 4;
  localparam int DP = 4;

  logic       clkin = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       tx, full, busy, ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: every accepted byte is a frame with its accept edge and its start (pop) edge.
  int         acc_q[$];
  int         s_q[$];
  logic [7:0] b_q[$];
  logic       m_ovf = 1'b0;

  uart_tx #(.DIVISOR(D), .DEPTH(DP)) dut (
    .clkin(clkin), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .ovf_clr(ovf_clr), .tx(tx), .full(full), .busy(busy), .ovf(ovf)
  );

  always #5 clkin = ~clkin;

  // Edge counter: value n after the n-th rising edge.
  always @(posedge clkin) cyc <= cyc + 1;

  function automatic logic exp_tx(int t);
    for (int i = 0; i < s_q.size(); i++) begin
      if (t >= s_q[i] && t < s_q[i] + 10 * D) begin
        int k;
        k = (t - s_q[i]) / D;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b_q[i][k-1];
      end
    end
    return 1'b1;
  endfunction

  function automatic logic exp_busy(int t);
    for (int i = 0; i < s_q.size(); i++)
      if (acc_q[i] <= t && t < s_q[i] + 10 * D) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int count_after(int t);
    int c;
    c = 0;
    for (int i = 0; i < s_q.size(); i++) begin
      if (acc_q[i] <= t) c++;
      if (s_q[i] <= t) c--;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic got, input logic expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%b expected=%b", tag, cyc, got, expv);
    end
  endtask

  task automatic model_reset();
    acc_q.delete();
    s_q.delete();
    b_q.delete();
    m_ovf = 1'b0;
  endtask

  // One clock: drive inputs at a falling edge, let the rising edge happen, update model, compare.
  task automatic cycle(input logic we, input logic [7:0] d, input logic clr);
    int e;
    logic dropped;
    wr_en = we;
    wr_data = d;
    ovf_clr = clr;
    @(negedge clkin);
    e = cyc;
    dropped = 1'b0;
    if (reset && we) begin
      if (count_after(e - 1) == DP) begin
        dropped = 1'b1;
        m_ovf = 1'b1;
      end else begin
        int s;
        s = e + 1;
        if (s_q.size() > 0 && s_q[s_q.size()-1] + 10 * D > s) s = s_q[s_q.size()-1] + 10 * D;
        acc_q.push_back(e);
        s_q.push_back(s);
        b_q.push_back(d);
      end
    end
    if (reset && clr && !dropped) m_ovf = 1'b0;
    chk("tx", tx, exp_tx(e));
    chk("busy", busy, exp_busy(e));
    chk("full", full, (count_after(e) == DP));
    chk("ovf", ovf, m_ovf);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    // Reset held with clock running.
    model_reset();
    idle(3);
    @(negedge clkin);
    reset = 1'b1;
    idle(100);

    // Single byte 0xA5.
    cycle(1'b1, 8'hA5, 1'b0);
    idle(45);

    // Back-to-back 0x00, 0xFF, 0x55.
    cycle(1'b1, 8'h00, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 8'h55, 1'b0);
    idle(130);

    // Five consecutive writes: all accepted.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
    chk("ovf_after5", ovf, 1'b0);
    idle(215);

    // Six consecutive writes: sixth dropped, then clear.
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'($urandom), 1'b0);
    chk("ovf_after6", ovf, 1'b1);
    idle(10);
    cycle(1'b0, 8'h00, 1'b1);
    chk("ovf_cleared", ovf, 1'b0);
    idle(215);

    // Set and clear in the same cycle while full: set wins.
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'($urandom), 1'b0);
    chk("full_before_setclr", full, 1'b1);
    cycle(1'b1, 8'($urandom), 1'b1);
    chk("ovf_setwins", ovf, 1'b1);
    idle(215);
    cycle(1'b0, 8'h00, 1'b1);

    // Randomized burst of writes and clears, then drain.
    for (int i = 0; i < 80; i++)
      cycle(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 9) == 0));
    idle(260);

    // Reset in the middle of data bit 3 of a 0x00 frame.
    cycle(1'b1, 8'h00, 1'b0);
    idle(1 + 4 * D + 1);
    chk("tx_bit3_low", tx, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("tx_async_reset", tx, 1'b1);
    chk("busy_async_reset", busy, 1'b0);
    chk("full_async_reset", full, 1'b0);
    idle(3);
    @(negedge clkin);
    reset = 1'b1;
    idle(60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
